// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: turns a decoded load/store into one data-bus
// transaction, holds it until data_ok, then returns extended load data.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        out_valid,
  output logic [63:0] out_rdata,
  output logic        out_misalign,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic        uns_q, uns_d;
  logic        load_q, load_d;
  logic        drop_q, drop_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  base_strobe;
  logic [2:0]  align_mask;
  logic [63:0] shifted_rdata;
  logic [63:0] ext_rdata;
  logic        unused_addr_ok;

  // Completion is signalled by data_ok alone.
  assign unused_addr_ok = dresp_addr_ok;

  always_comb begin
    base_strobe = 8'h01;
    align_mask  = 3'b000;
    case (mem_funct3[1:0])
      2'd0: begin base_strobe = 8'h01; align_mask = 3'b000; end
      2'd1: begin base_strobe = 8'h03; align_mask = 3'b001; end
      2'd2: begin base_strobe = 8'h0F; align_mask = 3'b011; end
      2'd3: begin base_strobe = 8'hFF; align_mask = 3'b111; end
      default: ;
    endcase
  end

  assign misaligned = |(mem_addr[2:0] & align_mask);
  assign accept     = mem_valid && (mem_load || mem_store) && !flush;

  assign shifted_rdata = dresp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    ext_rdata = shifted_rdata;
    case (size_q)
      2'd0: ext_rdata = uns_q ? {56'd0, shifted_rdata[7:0]}
                              : {{56{shifted_rdata[7]}}, shifted_rdata[7:0]};
      2'd1: ext_rdata = uns_q ? {48'd0, shifted_rdata[15:0]}
                              : {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
      2'd2: ext_rdata = uns_q ? {32'd0, shifted_rdata[31:0]}
                              : {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
      2'd3: ext_rdata = shifted_rdata;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    uns_d      = uns_q;
    load_d     = load_q;
    drop_d     = drop_q;
    misalign_d = misalign_q;
    stall      = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          addr_d     = mem_addr;
          size_d     = mem_funct3[1:0];
          uns_d      = mem_funct3[2];
          load_d     = mem_load;
          strobe_d   = mem_load ? 8'h00 : (base_strobe << mem_addr[2:0]);
          wdata_d    = mem_wdata << {mem_addr[2:0], 3'b000};
          rdata_d    = 64'd0;
          drop_d     = 1'b0;
          misalign_d = misaligned;
          state_d    = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (flush) drop_d = 1'b1;
        if (dresp_data_ok) begin
          rdata_d = load_q ? ext_rdata : 64'd0;
          drop_d  = 1'b0;
          // A flushed access still has to drain its bus response.
          state_d = (drop_q || flush) ? IDLE : DONE;
        end
      end
      DONE: begin
        out_valid = !flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      rdata_q    <= 64'd0;
      size_q     <= 2'd0;
      strobe_q   <= 8'd0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      uns_q      <= uns_d;
      load_q     <= load_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  assign dreq_valid   = (state_q == REQ);
  assign dreq_addr    = addr_q;
  assign dreq_size    = size_q;
  assign dreq_strobe  = strobe_q;
  assign dreq_data    = wdata_q;
  assign out_rdata    = rdata_q;
  assign out_misalign = misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized scoreboard bench for lsu_mem_stage with a byte-level reference
// model, a delaying bus responder and a decoupled result monitor.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_load, mem_store, flush;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_addr, mem_wdata;
  logic        stall, out_valid, out_misalign;
  logic [63:0] out_rdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_load(mem_load),
    .mem_store(mem_store), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .flush(flush), .stall(stall), .out_valid(out_valid),
    .out_rdata(out_rdata), .out_misalign(out_misalign), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        misalign;
  } res_t;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        is_store;
    logic [63:0] rdata;
    int          delay;
  } bus_t;

  // mode: 0 none, 1 flush on accept cycle, 2 flush from REQ on, 3 flush in DONE
  typedef struct {
    logic        load;
    logic        store;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          delay;
    int          mode;
  } op_t;

  res_t res_q[$];
  bus_t bus_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic logic [7:0] ref_strobe(input logic store, input logic [1:0] size, input int off);
    logic [7:0] s;
    int n;
    s = 8'h00;
    n = 1 << size;
    for (int i = 0; i < 8; i++)
      if (store && i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] w, input int off);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i >= off) r[8*i +: 8] = w[8*(i-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] f3, input int off);
    logic [63:0] r;
    int n;
    r = 64'd0;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) r[8*k +: 8] = d[8*(off+k) +: 8];
    if (!f3[2] && r[8*n-1])
      for (int k = n; k < 8; k++) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic op_t mk_op(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int delay, input int mode);
    op_t o;
    o.load = ld; o.store = st; o.f3 = f3; o.addr = addr; o.wdata = wdata;
    o.rdata = rdata; o.delay = delay; o.mode = mode;
    return o;
  endfunction

  task automatic do_op(input op_t op);
    int n, off, c, stall_cnt, exp_stall, done_c;
    logic memop, mis, done;
    bus_t b;
    res_t r;
    memop = op.load || op.store;
    n     = 1 << op.f3[1:0];
    off   = int'(op.addr[2:0]);
    mis   = memop && ((off % n) != 0);
    if (!memop || op.mode == 1) exp_stall = 0;
    else if (mis)               exp_stall = 1;
    else                        exp_stall = 2 + op.delay;
    done_c = mis ? 1 : 2 + op.delay;
    if (memop && !mis && op.mode != 1) begin
      b.addr = op.addr; b.size = op.f3[1:0];
      b.strobe = ref_strobe(op.store, op.f3[1:0], off);
      b.data = ref_wdata(op.wdata, off); b.is_store = op.store;
      b.rdata = op.rdata; b.delay = op.delay;
      bus_q.push_back(b);
    end
    if (memop && op.mode == 0) begin
      r.misalign = mis;
      r.rdata    = (mis || op.store) ? 64'd0 : ref_load(op.rdata, op.f3, off);
      res_q.push_back(r);
    end
    mem_valid = 1'b1; mem_load = op.load; mem_store = op.store;
    mem_funct3 = op.f3; mem_addr = op.addr; mem_wdata = op.wdata;
    flush = (op.mode == 1);
    c = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (stall) stall_cnt++;
      done = !stall;
      @(posedge clk); #1;
      if (done) break;
      c++;
      if (c > 60) begin
        n_checks++; n_fail++;
        $display("FAIL op_timeout: got stall stuck, expected release");
        break;
      end
      flush = (op.mode == 2 && c >= 1) || (op.mode == 3 && c == done_c);
    end
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0; flush = 1'b0;
  endtask

  // Bus responder: answers each request after its scripted delay, checking
  // that every request field stays stable while valid is high.
  initial begin : responder
    bus_t cur;
    bit   active;
    int   cnt;
    active = 0; cnt = 0;
    dresp_data_ok = 1'b0; dresp_data = 64'd0; dresp_addr_ok = 1'b0;
    forever begin
      @(posedge clk); #1;
      dresp_data_ok = 1'b0;
      dresp_addr_ok = 1'($urandom_range(0, 1));
      if (!dreq_valid) begin
        active = 0;
      end else begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_dreq: got valid at addr %0h, expected no request", dreq_addr);
            continue;
          end
          cur = bus_q.pop_front();
          active = 1; cnt = 0;
        end
        check("dreq_addr", dreq_addr, cur.addr);
        check("dreq_size_strobe", {54'd0, dreq_size, dreq_strobe}, {54'd0, cur.size, cur.strobe});
        if (cur.is_store) check("dreq_data", dreq_data, cur.data);
        if (cnt == cur.delay) begin
          dresp_data_ok = 1'b1;
          dresp_data    = cur.rdata;
          active = 0;
        end else begin
          cnt++;
          dresp_data = {$urandom, $urandom};
        end
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin : monitor
    res_t r;
    if (!reset && out_valid) begin
      if (res_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_out_valid: got out_valid=1, expected 0");
      end else begin
        r = res_q.pop_front();
        check("out_rdata", out_rdata, r.rdata);
        check("out_misalign", 64'(out_misalign), 64'(r.misalign));
      end
    end
  end

  initial begin : stimulus
    op_t op;
    int  kind, delay, mode, gap;
    logic [2:0]  f3;
    logic [63:0] addr;
    reset = 1'b1; mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    flush = 1'b0; mem_funct3 = 3'd0; mem_addr = 64'd0; mem_wdata = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_rdata", out_rdata, 64'd0);
    check("reset_out_misalign", 64'(out_misalign), 64'd0);
    check("reset_dreq_valid", 64'(dreq_valid), 64'd0);
    check("reset_dreq_addr", dreq_addr, 64'd0);
    @(posedge clk); #1;

    do_op(mk_op(1, 0, 3'b010, 64'h8000_0004, 64'd0, 64'h8000_0001_0000_0000, 0, 0));
    do_op(mk_op(0, 1, 3'b000, 64'h8000_0003, 64'hAB, 64'h1234, 3, 0));
    do_op(mk_op(1, 0, 3'b101, 64'h8000_0006, 64'd0, 64'hFFEE_0000_0000_0000, 1, 0));
    do_op(mk_op(1, 0, 3'b011, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0));
    do_op(mk_op(1, 0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0));
    do_op(mk_op(1, 0, 3'b010, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF, 3, 2));
    do_op(mk_op(0, 1, 3'b011, 64'h8000_0018, 64'h55, 64'd0, 0, 1));
    do_op(mk_op(1, 0, 3'b001, 64'h8000_0020, 64'd0, 64'hFFFF, 2, 3));
    do_op(mk_op(0, 0, 3'b000, 64'h8000_0000, 64'h7, 64'd0, 0, 0));

    // Reset while a request is outstanding
    bus_q.push_back('{addr: 64'h1000, size: 2'd3, strobe: 8'h00, data: 64'd0,
                      is_store: 1'b0, rdata: 64'd0, delay: 20});
    mem_valid = 1'b1; mem_load = 1'b1; mem_funct3 = 3'b011; mem_addr = 64'h1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; mem_valid = 1'b0; mem_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_req_stall", 64'(stall), 64'd0);
    check("rst_req_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      kind  = $urandom_range(0, 9);
      f3    = 3'($urandom_range(0, 7));
      addr  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      delay = $urandom_range(0, 4);
      mode  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      if (kind < 2) op = mk_op(0, 0, f3, addr, {$urandom, $urandom}, 64'd0, 0, 0);
      else if (kind < 6) begin
        if (f3 == 3'b111) f3 = 3'b011;
        op = mk_op(1, 0, f3, addr, 64'd0, {$urandom, $urandom}, delay, mode);
      end else op = mk_op(0, 1, {1'b0, f3[1:0]}, addr, {$urandom, $urandom},
                          {$urandom, $urandom}, delay, mode);
      do_op(op);
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("results_drained", 64'(res_q.size()), 64'd0);
    check("bus_drained", 64'(bus_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
